// File: rtl/boot_pkg.sv
// Shared constants for the UART boot loader:
// sync byte, loader/receiver state encodings and address helper.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [15:0] idx
    );
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a two-flop input synchronizer.
// Emits a one-cycle byte_valid or frame_err after the stop-bit sample.
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       RX,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

    logic        sync1;
    logic        rx_s;
    logic        rx_prev;
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= RX;
            rx_s       <= sync1;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                        cnt   <= 16'd1;
                    end
                end
                RX_START: begin
                    // A start bit that is high again by mid-bit is a glitch.
                    if (cnt == HALF) begin
                        cnt     <= 16'd1;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= 16'd1;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives A5, a 16-bit word count and little-endian
// words, writes them to instruction memory while stalling the CPU.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 87,
    parameter int          IMEM_WORDS     = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 20 * CLKS_PER_BIT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        RX,
    output logic        imem_WE,
    output logic [31:0] imem_A,
    output logic [31:0] imem_WD,
    output logic        cpu_stall,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic        byte_valid;
    logic        frame_err;
    logic [7:0]  byte_data;

    load_state_t state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  bidx;
    logic [23:0] word;
    logic [31:0] tmo;

    logic [15:0] len_new;
    logic [15:0] idx_next;
    logic        timeout;
    logic        abort;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .reset     (reset),
        .RX        (RX),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign len_new  = {byte_data, len_lo};
    assign idx_next = idx + 16'd1;
    assign timeout  = (tmo == TMO_LAST) && !byte_valid;
    assign abort    = (state != ST_IDLE) && (frame_err || timeout);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= ST_IDLE;
            imem_WE   <= 1'b0;
            imem_A    <= BASE_ADDR;
            imem_WD   <= '0;
            cpu_stall <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            len_lo    <= '0;
            len       <= '0;
            idx       <= '0;
            bidx      <= '0;
            word      <= '0;
            tmo       <= '0;
        end else begin
            imem_WE   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            // Idle-gap counter: cycles since the last received byte.
            if (state == ST_IDLE || byte_valid)
                tmo <= '0;
            else
                tmo <= tmo + 32'd1;

            if (abort) begin
                state     <= ST_IDLE;
                cpu_stall <= 1'b0;
                load_err  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (byte_valid && byte_data == SYNC_BYTE) begin
                            state     <= ST_LEN_LO;
                            cpu_stall <= 1'b1;
                        end
                    end
                    ST_LEN_LO: begin
                        if (byte_valid) begin
                            len_lo <= byte_data;
                            state  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (byte_valid) begin
                            len  <= len_new;
                            idx  <= '0;
                            bidx <= '0;
                            if (len_new == 16'd0) begin
                                state     <= ST_DONE;
                                load_done <= 1'b1;
                            end else if (len_new > MAX_WORDS) begin
                                state     <= ST_IDLE;
                                cpu_stall <= 1'b0;
                                load_err  <= 1'b1;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            bidx <= bidx + 2'd1;
                            unique case (bidx)
                                2'd0: word[7:0]   <= byte_data;
                                2'd1: word[15:8]  <= byte_data;
                                2'd2: word[23:16] <= byte_data;
                                default: begin
                                    state   <= ST_WRITE;
                                    imem_WE <= 1'b1;
                                    imem_A  <= word_addr(BASE_ADDR, idx);
                                    imem_WD <= {byte_data, word};
                                end
                            endcase
                        end
                    end
                    ST_WRITE: begin
                        idx <= idx_next;
                        if (idx_next < len) begin
                            state <= ST_DATA;
                        end else begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        cpu_stall <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cpu_stall <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with CLKS_PER_BIT=4, IMEM_WORDS=4.
// Expected writes and pulse counts are hand-computed per sequence.
module tb_uart_boot_loader;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        RX = 1'b1;
    logic        imem_WE;
    logic [31:0] imem_A;
    logic [31:0] imem_WD;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int failures = 0;

    int n_we = 0;
    int n_done = 0;
    int n_err = 0;
    int n_bv = 0;
    int n_fe = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        ws[$];
    logic        done_stall = 1'b0;

    int b_we, b_done, b_err, b_bv, b_fe, b_w;
    logic [7:0] seq[$];

    always #5 CLK = ~CLK;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .IMEM_WORDS  (4),
        .BASE_ADDR   (32'h0)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .RX       (RX),
        .imem_WE  (imem_WE),
        .imem_A   (imem_A),
        .imem_WD  (imem_WD),
        .cpu_stall(cpu_stall),
        .load_done(load_done),
        .load_err (load_err)
    );

    always @(negedge CLK) begin
        if (imem_WE) begin
            wa.push_back(imem_A);
            wd.push_back(imem_WD);
            ws.push_back(cpu_stall);
            n_we++;
        end
        if (load_done) begin
            n_done++;
            done_stall = cpu_stall;
        end
        if (load_err) n_err++;
        if (dut.byte_valid) n_bv++;
        if (dut.frame_err) n_fe++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge CLK) RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX = stop;
        repeat (CPB) @(negedge CLK);
        RX = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic snap();
        b_we   = n_we;
        b_done = n_done;
        b_err  = n_err;
        b_bv   = n_bv;
        b_fe   = n_fe;
        b_w    = wa.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_we", {31'b0, imem_WE}, 32'd0);
        chk("rst_a", imem_A, 32'h0);
        chk("rst_wd", imem_WD, 32'h0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge CLK);

        // Two-word load
        snap();
        send_byte(8'hA5);
        chk("l2_stall_a5", {31'b0, cpu_stall}, 32'd1);
        seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq);
        repeat (10) @(negedge CLK);
        chk("l2_nwe", n_we - b_we, 2);
        chk("l2_a0", wa[b_w], 32'h0);
        chk("l2_wd0", wd[b_w], 32'h12345678);
        chk("l2_st0", {31'b0, ws[b_w]}, 32'd1);
        chk("l2_a1", wa[b_w+1], 32'h4);
        chk("l2_wd1", wd[b_w+1], 32'hDEADBEEF);
        chk("l2_st1", {31'b0, ws[b_w+1]}, 32'd1);
        chk("l2_done", n_done - b_done, 1);
        chk("l2_done_stall", {31'b0, done_stall}, 32'd1);
        chk("l2_err", n_err - b_err, 0);
        chk("l2_stall_end", {31'b0, cpu_stall}, 32'd0);
        chk("l2_hold_a", imem_A, 32'h4);
        chk("l2_hold_wd", imem_WD, 32'hDEADBEEF);

        // Non-sync bytes ignored, then zero-length load
        snap();
        seq = '{8'h00, 8'hFF};
        send_seq(seq);
        chk("z_stall_pre", {31'b0, cpu_stall}, 32'd0);
        chk("z_done_pre", n_done - b_done, 0);
        send_byte(8'hA5);
        chk("z_stall_a5", {31'b0, cpu_stall}, 32'd1);
        seq = '{8'h00, 8'h00};
        send_seq(seq);
        repeat (10) @(negedge CLK);
        chk("z_nwe", n_we - b_we, 0);
        chk("z_done", n_done - b_done, 1);
        chk("z_stall_end", {31'b0, cpu_stall}, 32'd0);

        // Length above IMEM_WORDS aborts, then a good load
        snap();
        seq = '{8'hA5, 8'h05, 8'h00};
        send_seq(seq);
        repeat (10) @(negedge CLK);
        chk("big_err", n_err - b_err, 1);
        chk("big_nwe", n_we - b_we, 0);
        chk("big_stall", {31'b0, cpu_stall}, 32'd0);
        chk("big_done", n_done - b_done, 0);
        snap();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_seq(seq);
        repeat (10) @(negedge CLK);
        chk("rec_nwe", n_we - b_we, 1);
        chk("rec_a", wa[b_w], 32'h0);
        chk("rec_wd", wd[b_w], 32'h11223344);
        chk("rec_done", n_done - b_done, 1);

        // Framing error mid-word
        snap();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(seq);
        send_byte(8'h33, 1'b0);
        repeat (10) @(negedge CLK);
        chk("fe_cnt", n_fe - b_fe, 1);
        chk("fe_err", n_err - b_err, 1);
        chk("fe_nwe", n_we - b_we, 0);
        chk("fe_stall", {31'b0, cpu_stall}, 32'd0);

        // Inter-byte timeout
        snap();
        send_seq(seq);
        repeat (50) @(negedge CLK);
        chk("tmo_early", n_err - b_err, 0);
        chk("tmo_stall_mid", {31'b0, cpu_stall}, 32'd1);
        repeat (50) @(negedge CLK);
        chk("tmo_err", n_err - b_err, 1);
        chk("tmo_nwe", n_we - b_we, 0);
        chk("tmo_stall", {31'b0, cpu_stall}, 32'd0);

        // Reset in the middle of word 1
        snap();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA};
        send_seq(seq);
        chk("mr_stall_pre", {31'b0, cpu_stall}, 32'd1);
        @(negedge CLK) reset = 1'b1;
        @(negedge CLK);
        chk("mr_stall", {31'b0, cpu_stall}, 32'd0);
        chk("mr_we", {31'b0, imem_WE}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        chk("mr_err", n_err - b_err, 0);
        chk("mr_nwe", n_we - b_we, 1);
        chk("mr_a0", wa[b_w], 32'h0);
        chk("mr_wd0", wd[b_w], 32'h12345678);

        // One-cycle low glitch on idle line
        snap();
        @(negedge CLK) RX = 1'b0;
        @(negedge CLK) RX = 1'b1;
        repeat (20) @(negedge CLK);
        chk("gl_bv", n_bv - b_bv, 0);
        chk("gl_fe", n_fe - b_fe, 0);
        chk("gl_stall", {31'b0, cpu_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, giving CLK cycles per UART bit (115200 baud at 10 MHz).
REQ-002 The block SHALL have parameter IMEM_WORDS, default 64, giving the maximum number of words in one load.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0, giving the byte address of the first instruction word.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 20*CLKS_PER_BIT, giving the longest idle gap allowed between bytes of a load.
REQ-005 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port RX, input, 1 bit: asynchronous UART receive line, idle high, 8N1, LSB first.
REQ-008 Port imem_WE, output, 1 bit: instruction memory write strobe.
REQ-009 Port imem_A, output, 32 bits: instruction memory byte address.
REQ-010 Port imem_WD, output, 32 bits: instruction memory write data.
REQ-011 Port cpu_stall, output, 1 bit: holds the processor pipeline while a load is in progress.
REQ-012 Port load_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-013 Port load_err, output, 1 bit: one-cycle pulse when a load is aborted.

Function
REQ-014 RX SHALL pass through a two-flop synchronizer before any use; the synchronized line is referred to below as rx_s.
REQ-015 Byte receiver: a 1-to-0 transition on rx_s starts a frame.
- Start bit is sampled CLKS_PER_BIT/2 cycles later; if rx_s is high there, the frame is discarded silently.
- The 8 data bits and the stop bit are each sampled CLKS_PER_BIT cycles apart.
REQ-016 The byte receiver SHALL raise byte_valid for exactly one cycle, stop-bit sample cycle + 1, when the stop bit is high; a low stop bit SHALL raise frame_err for one cycle instead.
REQ-017 Loader state machine states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
REQ-018 IDLE: a received byte equal to 8'hA5 moves the state to LEN_LO and sets cpu_stall on the next cycle; any other byte is ignored.
REQ-019 LEN_LO then LEN_HI capture the 16-bit word count N, little-endian.
- N = 0: go to DONE.
- N > IMEM_WORDS: abort.
- Otherwise: go to DATA with word index 0 and byte index 0.
REQ-020 DATA: four bytes SHALL assemble into a 32-bit word, little-endian (first byte goes to [7:0]); after the fourth byte, go to WRITE.
REQ-021 WRITE (one cycle): imem_WE=1, imem_A=BASE_ADDR + 4*index, imem_WD=the assembled word.
- Index then increments; go to DATA if index < N, else to DONE.
REQ-022 Address arithmetic SHALL be 32-bit modulo 2^32; index is 16 bits.
REQ-023 DONE (one cycle): load_done=1, cpu_stall=0 from the next cycle, return to IDLE.
REQ-024 Abort: from any state other than IDLE, either of the following causes a one-cycle load_err, cpu_stall=0 on the next cycle, and a return to IDLE with no further writes:
- a frame_err;
- the inter-byte timeout (TIMEOUT_CYCLES with no byte_valid).
REQ-025 In IDLE, a frame_err SHALL be ignored and no timeout runs.
REQ-026 cpu_stall SHALL be high in every state except IDLE, including during the WRITE cycle.
REQ-027 imem_A and imem_WD SHALL hold their last written values when imem_WE=0.
REQ-028 A byte_valid that coincides with the WRITE cycle cannot occur, because the minimum byte period exceeds one cycle; no queuing is required.

Reset
REQ-029 While reset=1, at the next rising edge, the block SHALL set:
- the state machine to IDLE and the receiver to idle;
- the synchronizer flops to 1;
- imem_WE=0, imem_A=BASE_ADDR, imem_WD=0;
- cpu_stall=0, load_done=0, load_err=0;
- all counters to 0.
REQ-030 A reset during a load SHALL abandon it without a load_err pulse; words already written stay written.

Structure
REQ-031 The sync byte 8'hA5 and the state encodings SHALL be defined as constants in a shared package, boot_pkg.
REQ-032 The byte receiver (REQ-015 and REQ-016) SHALL be a sub-module named uart_rx_byte with outputs byte_valid, byte_data[7:0] and frame_err; the loader FSM SHALL be in uart_boot_loader.

Verification (CLKS_PER_BIT=4, IMEM_WORDS=4, BASE_ADDR=0)
REQ-033 Send A5 02 00 78 56 34 12 EF BE AD DE -> two writes: (A=0, WD=12345678) then (A=4, WD=DEADBEEF); then one load_done pulse; cpu_stall high from after A5 until the cycle after DONE.
REQ-034 Send 00 FF then A5 00 00 -> no writes; a single load_done; cpu_stall high only between A5 and DONE.
REQ-035 Send A5 05 00 -> load_err pulse, no imem_WE, cpu_stall low; a following valid load still succeeds.
REQ-036 Send A5 01 00 11 22 with the next byte's stop bit forced low -> load_err, no write.
REQ-036a Same prefix (A5 01 00 11 22), then RX held high for 80 cycles -> load_err, no write.
REQ-037 Assert reset mid-DATA after A5 02 00 78 56 34 12 AA -> cpu_stall=0 and imem_WE=0 from the next edge, no load_err; word 0 was written.
REQ-038 A 1-cycle low glitch on RX while idle -> no byte_valid and no frame_err.
